// File: rtl/mvm_par_stream_if.sv
// mvm_par_stream_if
//   Generic valid/ready/data stream bundle used for both the element load
//   path (W = B) and the result path (W = OW) of mvm_par_stream.
//   master: drives valid/data, receives ready.
//   slave : receives valid/data, drives ready.
interface mvm_par_stream_if #(parameter int W = 8);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/mvm_par_stream.sv
// mvm_par_stream
//   Matrix-vector multiplier y = A*x with P parallel MAC lanes.
//   A (KxK, row-major) and x (K) are loaded over in_s; the K results are
//   streamed out over out_m in index order with backpressure.
//   Optional: define MVM_RELU_EN to clamp negative y values to 0 before
//   they are stored.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   loadMatrix/loadVector command pulses (sampled in IDLE only)
//   start                 command pulse: compute y
//   in_s  (slave)         element stream, B-bit signed data
//   out_m (master)        result stream, OW-bit signed data
//   busy                  high whenever not IDLE
//   done                  high in the cycle y[K-1] is accepted

// Per-lane datapath: registered A read -> multiply register -> accumulate.
module mvm_par_lane #(
  parameter int B  = 8,
  parameter int OW = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue,   // A element on a_el is valid this cycle
  input  logic                 mul_en,  // a_rd_q/x_rd hold a valid pair
  input  logic                 acc_en,  // prod_q holds a valid product
  input  logic                 clr,     // last cycle of the row group
  input  logic signed [B-1:0]  a_el,
  input  logic signed [B-1:0]  x_rd,
  output logic signed [OW-1:0] y_val
);
  logic signed [B-1:0]    a_rd_q, a_rd_d;
  logic signed [2*B-1:0]  prod_q, prod_d;
  logic signed [OW-1:0]   acc_q, acc_d, prod_ext, sum;

  always_comb begin
    a_rd_d   = issue  ? a_el : a_rd_q;
    prod_d   = mul_en ? a_rd_q * x_rd : prod_q;
    prod_ext = OW'(prod_q);
    sum      = acc_en ? acc_q + prod_ext : acc_q;
    // the final product lands in the same cycle the group ends, so y is
    // taken from the sum rather than from acc_q
    acc_d    = clr ? '0 : sum;
`ifdef MVM_RELU_EN
    y_val    = sum[OW-1] ? '0 : sum;
`else
    y_val    = sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rd_q <= '0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      a_rd_q <= a_rd_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end
endmodule

module mvm_par_stream #(
  parameter int K    = 8,
  parameter int LOGK = 3,
  parameter int B    = 8,
  parameter int P    = 2,
  parameter int OW   = 2*B+LOGK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loadMatrix,
  input  logic             loadVector,
  input  logic             start,
  mvm_par_stream_if.slave  in_s,
  mvm_par_stream_if.master out_m,
  output logic             busy,
  output logic             done
);
  localparam int NG = K / P;
  localparam int AW = $clog2(K*K);
  localparam int IW = $clog2(K);
  localparam int CW = $clog2(K+2);
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_X  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [AW-1:0]        ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [GW-1:0]        grp_q, grp_d;
  logic [IW-1:0]        out_i_q, out_i_d;
  logic                 out_valid_q, out_valid_d;
  logic [OW-1:0]        data_out_q, data_out_d;
  logic signed [B-1:0]  x_rd_q, x_rd_d;
  logic [2:1]           vld_pipe_q;
  logic [2:0]           vld_pipe;

  logic [B-1:0]         a_mem [K*K];
  logic [B-1:0]         x_mem [K];
  logic [OW-1:0]        y_mem [K];

  logic                 accept_in, accept_out, issue, grp_end;
  logic [IW-1:0]        cidx;
  logic [P-1:0][AW-1:0] a_addr;
  logic [P-1:0][OW-1:0] lane_y;

  assign in_s.ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_X);
  assign accept_in   = in_s.valid && in_s.ready;
  assign out_m.valid = out_valid_q;
  assign out_m.data  = data_out_q;
  assign accept_out  = out_valid_q && out_m.ready;
  assign busy        = (state_q != S_IDLE);
  assign done        = accept_out && (out_i_q == IW'(K-1));

  // Stage 0 issues reads for column cnt while cnt < K; stages 1/2 are the
  // multiply and accumulate steps of the same element.
  assign issue    = (state_q == S_COMPUTE) && (cnt_q < CW'(K));
  assign grp_end  = (state_q == S_COMPUTE) && (cnt_q == CW'(K+1));
  assign cidx     = cnt_q[IW-1:0];
  assign vld_pipe = {vld_pipe_q, issue};
  assign x_rd_d   = issue ? x_mem[cidx] : x_rd_q;

  for (genvar p = 0; p < P; p++) begin : g_lane
    assign a_addr[p] = AW'((int'(grp_q)*P + p)*K + int'(cidx));
    mvm_par_lane #(.B(B), .OW(OW)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .issue  (vld_pipe[0]),
      .mul_en (vld_pipe[1]),
      .acc_en (vld_pipe[2]),
      .clr    (grp_end),
      .a_el   (a_mem[a_addr[p]]),
      .x_rd   (x_rd_q),
      .y_val  (lane_y[p])
    );
  end

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    cnt_d       = cnt_q;
    grp_d       = grp_q;
    out_i_d     = out_i_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    case (state_q)
      S_IDLE: begin
        ld_cnt_d = '0;
        if (loadMatrix)      state_d = S_LOAD_A;
        else if (loadVector) state_d = S_LOAD_X;
        else if (start) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
          grp_d   = '0;
        end
      end
      S_LOAD_A: if (accept_in) begin
        ld_cnt_d = ld_cnt_q + 1'b1;
        if (ld_cnt_q == AW'(K*K-1)) begin
          state_d  = S_IDLE;
          ld_cnt_d = '0;
        end
      end
      S_LOAD_X: if (accept_in) begin
        ld_cnt_d = ld_cnt_q + 1'b1;
        if (ld_cnt_q == AW'(K-1)) begin
          state_d  = S_IDLE;
          ld_cnt_d = '0;
        end
      end
      S_COMPUTE: begin
        if (grp_end) begin
          cnt_d = '0;
          if (grp_q == GW'(NG-1)) begin
            state_d = S_OUTPUT;
            grp_d   = '0;
            out_i_d = '0;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUTPUT: begin
        // y storage takes its last write on the final COMPUTE edge, so the
        // first cycle here only primes the output register.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          data_out_d  = y_mem[out_i_q];
        end else if (out_m.ready) begin
          if (out_i_q == IW'(K-1)) begin
            out_valid_d = 1'b0;
            out_i_d     = '0;
            state_d     = S_IDLE;
          end else begin
            out_i_d    = out_i_q + 1'b1;
            data_out_d = y_mem[out_i_q + 1'b1];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ld_cnt_q    <= '0;
      cnt_q       <= '0;
      grp_q       <= '0;
      out_i_q     <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      x_rd_q      <= '0;
      vld_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      cnt_q       <= cnt_d;
      grp_q       <= grp_d;
      out_i_q     <= out_i_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      x_rd_q      <= x_rd_d;
      vld_pipe_q  <= vld_pipe[1:0];
    end
  end

  // Storage is deliberately not reset so a restart can reuse loaded A/x.
  always_ff @(posedge clk) begin
    if (!reset && accept_in) begin
      if (state_q == S_LOAD_A) a_mem[ld_cnt_q]         <= in_s.data;
      else                     x_mem[ld_cnt_q[IW-1:0]] <= in_s.data;
    end
    if (!reset && grp_end) begin
      for (int p = 0; p < P; p++)
        y_mem[IW'(int'(grp_q)*P + p)] <= lane_y[p];
    end
  end
endmodule

// File: tb/tb_mvm_par_stream.sv
module tb_mvm_par_stream;
  localparam int K = 8, LOGK = 3, B = 8, P = 2, OW = 2*B+LOGK;

  logic clk = 1'b0;
  logic reset = 1'b1, loadMatrix = 1'b0, loadVector = 1'b0, start = 1'b0;
  logic busy, done;

  mvm_par_stream_if #(.W(B))  in_if();
  mvm_par_stream_if #(.W(OW)) out_if();

  mvm_par_stream #(.K(K), .LOGK(LOGK), .B(B), .P(P), .OW(OW)) dut (
    .clk        (clk),
    .reset      (reset),
    .loadMatrix (loadMatrix),
    .loadVector (loadVector),
    .start      (start),
    .in_s       (in_if.slave),
    .out_m      (out_if.master),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int am [K*K];
  int xv [K];
  longint ye [K];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: y = A*x in plain integer arithmetic.
  task automatic model();
    for (int i = 0; i < K; i++) begin
      longint s = 0;
      for (int j = 0; j < K; j++) s += longint'(am[i*K+j]) * longint'(xv[j]);
`ifdef MVM_RELU_EN
      if (s < 0) s = 0;
`endif
      ye[i] = s;
    end
  endtask

  task automatic load(input bit matrix, input bit gaps, input bit inject,
                      input bit with_start);
    int n_el = matrix ? K*K : K;
    int v;
    @(negedge clk);
    loadMatrix = matrix;
    loadVector = !matrix;
    start      = with_start;
    @(negedge clk);
    loadMatrix = 1'b0; loadVector = 1'b0; start = 1'b0;
    chk("ld_entry_ready", in_if.ready, 1);
    for (int n = 0; n < n_el; n++) begin
      if (gaps) begin
        in_if.valid = 1'b0;
        in_if.data  = B'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      v = matrix ? am[n] : xv[n];
      in_if.valid = 1'b1;
      in_if.data  = B'(v);
      if (inject && n == 3) begin
        loadVector = 1'b1;
        start      = 1'b1;
      end
      @(negedge clk);
      loadVector = 1'b0;
      start      = 1'b0;
    end
    in_if.valid = 1'b0;
    chk("ld_exit_ready", in_if.ready, 0);
    chk("ld_exit_busy", busy, 0);
  endtask

  function automatic bit rdy(input int pat, input int cyc);
    case (pat)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run(input int pat);
    int lat = 0, idx = 0, cyc = 0;
    bit stalled = 0, r;
    logic [OW-1:0] held = '0;
    out_if.ready = rdy(pat, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!out_if.valid && lat < 200) begin
      if (lat == 20) chk("busy_compute", busy, 1);
      @(negedge clk);
      lat++;
    end
    chk("first_valid_latency", lat, 41);
    while (idx < K && cyc < 400) begin
      r = rdy(pat, cyc);
      out_if.ready = r;
      #1;
      if (out_if.valid) begin
        if (stalled) chk("stall_hold", $signed(out_if.data), $signed(held));
        if (r) begin
          chk("y", $signed(out_if.data), ye[idx]);
          chk("done", done, (idx == K-1));
          idx++;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = out_if.data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("all_outputs", idx, K);
    chk("post_valid", out_if.valid, 0);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    out_if.ready = 1'b0;
  endtask

  task automatic fill_ident();
    for (int i = 0; i < K*K; i++) am[i] = (i / K == i % K) ? 1 : 0;
    for (int j = 0; j < K; j++) xv[j] = j + 1;
  endtask

  initial begin
    bit saw_done;
    in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_if.valid, 0);
    chk("rst_in_ready", in_if.ready, 0);
    chk("rst_done", done, 0);
    chk("rst_data_out", out_if.data, 0);
    reset = 1'b0;

    // identity A, x = 1..8
    fill_ident(); model();
    load(1, 0, 0, 0); load(0, 0, 0, 0);
    run(0);

    // extreme magnitudes
    for (int i = 0; i < K*K; i++) am[i] = -128;
    for (int j = 0; j < K; j++) xv[j] = -128;
    model();
    chk("model_extreme", ye[0], 131072);
    load(1, 0, 0, 0); load(0, 0, 0, 0);
    run(0);

    // signed rows: row i all i-3, x all 1
    for (int i = 0; i < K*K; i++) am[i] = i / K - 3;
    for (int j = 0; j < K; j++) xv[j] = 1;
    model();
    load(1, 0, 0, 0); load(0, 0, 0, 0);
    run(0);

    // gapped loads and 1-0-0-1 backpressure
    fill_ident(); model();
    load(1, 1, 0, 0); load(0, 1, 0, 0);
    run(1);

    // reset in the middle of COMPUTE, then restart from retained A/x
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_if.valid, 0);
    saw_done = 0;
    repeat (50) begin
      @(negedge clk);
      if (done || out_if.valid) saw_done = 1;
    end
    chk("abort_quiet", saw_done, 0);
    run(0);

    // commands during LOAD_A ignored; random data
    for (int i = 0; i < K*K; i++) am[i] = $signed(8'($urandom));
    for (int j = 0; j < K; j++) xv[j] = $signed(8'($urandom));
    model();
    load(1, 0, 1, 0); load(0, 1, 0, 0);
    run(2);

    // loadMatrix + start together enters LOAD_A
    for (int i = 0; i < K*K; i++) am[i] = $signed(8'($urandom));
    for (int j = 0; j < K; j++) xv[j] = $signed(8'($urandom));
    model();
    load(1, 1, 0, 1); load(0, 0, 0, 0);
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
